// File: rtl/scoreboard_ctrl_pkg.sv
// scoreboard_ctrl_pkg
//   Shared parameters and types for the ID->EXE issue scoreboard.
//   REG_ADDR_SIZE : MSB index of a register address (5-bit addresses).
//   SB_CNT_W      : default width of each pending-write counter.
//   sb_state_e    : drain handshake state encodings.
package scoreboard_ctrl_pkg;

  localparam int REG_ADDR_SIZE = 4;
  localparam int SB_CNT_W      = 2;

  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_DRAIN = 2'd1,
    SB_DONE  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/sb_pend_cnt.sv
// sb_pend_cnt
//   Pending-write counter for one architectural register.
//   clk, rst_n : clock, async active-low reset
//   inc        : an instruction writing this register issues
//   dec        : a writeback to this register retires
//   cnt        : current count of in-flight writers
//   zero, full : count is 0 / count is at its maximum
//   underflow  : writeback seen while no writer is outstanding
module sb_pend_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             full,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign zero      = (cnt_q == '0);
  assign full      = (cnt_q == '1);
  assign underflow = dec & zero;
  assign cnt       = cnt_q;

  // Simultaneous inc and dec cancel. Saturation on both ends keeps a stray
  // writeback from wrapping the count; the issue gate prevents increments at full.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !full) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && !zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl
//   Issue controller at the ID->EXE boundary. Keeps one pending-write counter
//   per architectural register (x0 untracked), blocks issue on RAW hazards and
//   on a destination counter that would overflow, and provides a drain
//   handshake used by fence/CSR/ecall.
//
//   Inputs : clk, rst_n, id_valid, id_rs1/id_rs2 (+ _used), id_rd, id_rd_valid,
//            exe_ready, flush, wb_valid, wb_rd, drain_req
//   Outputs: issue, stall (combinational), drain_ack, err (registered)
//
//   Optional: SCOREBOARD_STALL_CNT_EN adds output stall_cycles[31:0], a free-
//   running count of cycles with stall asserted.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   SB_RUN   | normal operation, issue allowed when hazard-free
//   SB_DRAIN | drain requested, waiting for all pending writes to retire
//   SB_DONE  | no writes pending, drain_ack asserted until request drops
module scoreboard_ctrl
  import scoreboard_ctrl_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_ADDR_SIZE:0] id_rs1,
  input  logic [REG_ADDR_SIZE:0] id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [REG_ADDR_SIZE:0] id_rd,
  input  logic                   id_rd_valid,
  input  logic                   exe_ready,
  input  logic                   flush,
  input  logic                   wb_valid,
  input  logic [REG_ADDR_SIZE:0] wb_rd,
  input  logic                   drain_req,
  output logic                   issue,
  output logic                   stall,
  output logic                   drain_ack,
  output logic                   err
`ifdef SCOREBOARD_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int AW = REG_ADDR_SIZE + 1;

  logic [NREGS-1:0] eff_zero;
  logic [NREGS-1:0] eff_full;
  logic [NREGS-1:0] underflow;
  logic             hazard;
  logic             all_clear;

  sb_state_e state_q, state_d;
  logic      err_q, err_d;

  genvar r;
  generate
    for (r = 0; r < NREGS; r++) begin : g_reg
      if (r == 0) begin : g_x0
        assign eff_zero[r]  = 1'b1;
        assign eff_full[r]  = 1'b0;
        assign underflow[r] = 1'b0;
      end else begin : g_cnt
        logic             inc_r;
        logic             dec_r;
        logic [CNT_W-1:0] cnt_r;
        logic             zero_r;
        logic             full_r;

        assign inc_r = issue & id_rd_valid & (id_rd == AW'(r));
        assign dec_r = wb_valid & (wb_rd == AW'(r));

        sb_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
          .clk       (clk),
          .rst_n     (rst_n),
          .inc       (inc_r),
          .dec       (dec_r),
          .cnt       (cnt_r),
          .zero      (zero_r),
          .full      (full_r),
          .underflow (underflow[r])
        );

        // Effective count subtracts a same-cycle writeback: the register file
        // is write-through, so the retiring value is already readable.
        assign eff_zero[r] = zero_r | (dec_r & (cnt_r == CNT_W'(1)));
        assign eff_full[r] = full_r & ~dec_r;
      end
    end
  endgenerate

  assign hazard = (id_rs1_used && (id_rs1 != '0) && !eff_zero[id_rs1]) ||
                  (id_rs2_used && (id_rs2 != '0) && !eff_zero[id_rs2]) ||
                  (id_rd_valid && (id_rd  != '0) &&  eff_full[id_rd]);

  assign all_clear = &eff_zero;

  // drain_req blocks issue combinationally so nothing slips out in the
  // request cycle while the FSM is still in RUN.
  assign issue = id_valid && exe_ready && !flush && !hazard &&
                 (state_q == SB_RUN) && !drain_req;
  assign stall = id_valid && !flush && !issue;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_RUN:   if (drain_req) state_d = SB_DRAIN;
      SB_DRAIN: begin
        if (!drain_req)     state_d = SB_RUN;
        else if (all_clear) state_d = SB_DONE;
      end
      SB_DONE:  if (!drain_req) state_d = SB_RUN;
      default:  state_d = SB_RUN;
    endcase
  end

  assign err_d = err_q | (|underflow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SB_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign drain_ack = (state_q == SB_DONE);
  assign err       = err_q;

`ifdef SCOREBOARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = stall_cnt_q + 32'(stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_scoreboard_ctrl.sv
module tb_scoreboard_ctrl;
  import scoreboard_ctrl_pkg::*;

  localparam int NR  = 32;
  localparam int MAX = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic                   id_valid, id_rs1_used, id_rs2_used, id_rd_valid;
  logic [REG_ADDR_SIZE:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic                   exe_ready, flush, wb_valid, drain_req;
  logic                   issue, stall, drain_ack, err;
`ifdef SCOREBOARD_STALL_CNT_EN
  logic [31:0] stall_cycles;
  int          stall_m;
`endif

  int errors = 0;
  int checks = 0;

  // reference state: pending writers per register, sticky error, drain phase
  int cnt_m [NR];
  bit err_m;
  int ph_m; // 0 = running, 1 = draining, 2 = drained

  scoreboard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_valid(id_rd_valid), .exe_ready(exe_ready), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .drain_req(drain_req),
    .issue(issue), .stall(stall), .drain_ack(drain_ack), .err(err)
`ifdef SCOREBOARD_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  function automatic int m_eff(int r);
    int e;
    if (r == 0) return 0;
    e = cnt_m[r];
    if (wb_valid && int'(wb_rd) == r && e != 0) e = e - 1;
    return e;
  endfunction

  function automatic bit m_issue();
    bit hz;
    hz = (id_rs1_used && m_eff(int'(id_rs1)) != 0) ||
         (id_rs2_used && m_eff(int'(id_rs2)) != 0) ||
         (id_rd_valid && id_rd != 0 && m_eff(int'(id_rd)) == MAX);
    return id_valid && exe_ready && !flush && !hz && ph_m == 0 && !drain_req;
  endfunction

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_valid = 0; exe_ready = 1; flush = 0;
    wb_valid = 0; wb_rd = 0; drain_req = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();
  endtask

  task automatic instr(input bit v, input int rs1, input bit u1, input int rd, input bit rdv);
    id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 0; id_rs2_used = 0;
    id_rd = 5'(rd); id_rd_valid = rdv;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    instr(1, 0, 0, 4, 1);
    #2;
    checks++; if (drain_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", drain_ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL reset_issue: got %b want 1", issue); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
`ifdef SCOREBOARD_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stallcnt: got %0d want 0", stall_cycles); end
`endif
    do_reset();
  endtask

  task automatic test_raw();
    do_reset();
    instr(1, 0, 0, 5, 1); #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_producer: issue %b want 1", issue); end
    tick();
    instr(1, 5, 1, 6, 1);
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if (issue !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL raw_stall t+%0d: issue %b stall %b want 0 1", c, issue, stall); end
      tick();
    end
    wb_valid = 1; wb_rd = 5; #1;
    checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL raw_wb_issue: issue %b stall %b want 1 0", issue, stall); end
    tick();
    wb_valid = 0; instr(1, 5, 1, 0, 0); #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_cleared: issue %b want 1", issue); end
    tick();
  endtask

  task automatic test_waw_full();
    do_reset();
    instr(1, 0, 0, 7, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_writer%0d: issue %b want 1", c, issue); end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (issue !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL waw_full%0d: issue %b stall %b want 0 1", c, issue, stall); end
      tick();
    end
    wb_valid = 1; wb_rd = 7; #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_release: issue %b want 1", issue); end
    tick();
    wb_valid = 0; #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL waw_refull: issue %b want 0", issue); end
    tick();
  endtask

  task automatic test_inc_dec();
    do_reset();
    instr(1, 0, 0, 9, 1); tick();
    wb_valid = 1; wb_rd = 9; #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL incdec_issue: issue %b want 1", issue); end
    tick();
    wb_valid = 0; instr(1, 9, 1, 0, 0); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL incdec_err: got %b want 0", err); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL incdec_still1: stall %b want 1", stall); end
    tick();
    wb_valid = 1; wb_rd = 9; #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL incdec_wb: issue %b want 1", issue); end
    tick();
    wb_valid = 0; #1;
    checks++; if (issue !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL incdec_zero: issue %b err %b want 1 0", issue, err); end
    tick();
  endtask

  task automatic test_err();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      instr(1, 0, 0, 0, 1); wb_valid = 1; wb_rd = 0; #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL x0_write%0d: issue %b want 1", c, issue); end
      tick();
    end
    instr(1, 0, 1, 0, 0); wb_valid = 0; #1;
    checks++; if (err !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL x0_noerr: err %b issue %b want 0 1", err, issue); end
    tick();
    idle(); wb_valid = 1; wb_rd = 12; #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", err); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
    wb_valid = 0;
    repeat (3) tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_drain();
    do_reset();
    instr(1, 0, 0, 3, 1); tick(); tick();
    instr(1, 0, 0, 10, 1); drain_req = 1; #1;
    checks++; if (issue !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL drain_block: issue %b stall %b want 0 1", issue, stall); end
    tick();
    checks++; if (drain_ack !== 1'b0) begin errors++; $display("FAIL drain_early: ack %b want 0", drain_ack); end
    wb_valid = 1; wb_rd = 3; tick();
    checks++; if (drain_ack !== 1'b0) begin errors++; $display("FAIL drain_one_left: ack %b want 0", drain_ack); end
    tick();
    wb_valid = 0;
    checks++; if (drain_ack !== 1'b1) begin errors++; $display("FAIL drain_ack: got %b want 1", drain_ack); end
    drain_req = 0; #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL drain_done_block: issue %b want 0", issue); end
    tick();
    checks++; if (issue !== 1'b1 || drain_ack !== 1'b0) begin errors++; $display("FAIL drain_resume: issue %b ack %b want 1 0", issue, drain_ack); end
    idle(); drain_req = 1; tick();
    checks++; if (drain_ack !== 1'b0) begin errors++; $display("FAIL drain_empty1: ack %b want 0", drain_ack); end
    tick();
    checks++; if (drain_ack !== 1'b1) begin errors++; $display("FAIL drain_empty2: ack %b want 1", drain_ack); end
    drain_req = 0; tick();
  endtask

  task automatic test_flush_and_reset();
    do_reset();
    instr(1, 0, 0, 11, 1); flush = 1; #1;
    checks++; if (issue !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush: issue %b stall %b want 0 0", issue, stall); end
    tick();
    flush = 0; instr(1, 11, 1, 0, 0); #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL flush_nocount: issue %b want 1", issue); end
    tick();
    instr(1, 0, 0, 3, 1); tick();
    idle(); drain_req = 1; tick(); tick();
    wb_valid = 1; wb_rd = 12; tick();
    wb_valid = 0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rst_pre_err: got %b want 1", err); end
    drain_req = 0; instr(1, 3, 1, 0, 0);
    rst_n = 0; #1;
    checks++; if (err !== 1'b0 || drain_ack !== 1'b0) begin errors++; $display("FAIL rst_async: err %b ack %b want 0 0", err, drain_ack); end
    checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL rst_async_issue: issue %b stall %b want 1 0", issue, stall); end
    tick(); rst_n = 1; tick();
  endtask

  task automatic test_random();
    bit ei, es, az;
    int nph;
    int ncnt [NR];
    bit nerr;
    do_reset();
    for (int r = 0; r < NR; r++) cnt_m[r] = 0;
    err_m = 0; ph_m = 0;
`ifdef SCOREBOARD_STALL_CNT_EN
    stall_m = 0;
`endif
    for (int c = 0; c < 600; c++) begin
      int wr;
      id_valid = ($urandom_range(0, 9) < 8);
      id_rs1 = 5'($urandom_range(0, 7)); id_rs1_used = 1'($urandom);
      id_rs2 = 5'($urandom_range(0, 7)); id_rs2_used = 1'($urandom);
      id_rd  = 5'($urandom_range(0, 7)); id_rd_valid = 1'($urandom);
      exe_ready = ($urandom_range(0, 9) < 8);
      flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) drain_req = !drain_req;
      wr = $urandom_range(1, 7);
      wb_valid = (cnt_m[wr] > 0) && ($urandom_range(0, 9) < 5);
      wb_rd = 5'(wr);
      if ($urandom_range(0, 19) == 0) begin wb_valid = 1; wb_rd = 0; end
      ei = m_issue();
      es = id_valid && !flush && !ei;
      #1;
      checks++; if (issue !== ei) begin errors++; $display("FAIL rnd_issue cyc %0d: got %b want %b", c, issue, ei); end
      checks++; if (stall !== es) begin errors++; $display("FAIL rnd_stall cyc %0d: got %b want %b", c, stall, es); end
      az = 1;
      for (int r = 1; r < NR; r++) if (m_eff(r) != 0) az = 0;
      nph = ph_m;
      if (ph_m == 0 && drain_req) nph = 1;
      else if (ph_m == 1) nph = !drain_req ? 0 : (az ? 2 : 1);
      else if (ph_m == 2 && !drain_req) nph = 0;
      nerr = err_m;
      for (int r = 1; r < NR; r++) begin
        int inc, dec;
        inc = (ei && id_rd_valid && int'(id_rd) == r) ? 1 : 0;
        dec = (wb_valid && int'(wb_rd) == r) ? 1 : 0;
        ncnt[r] = cnt_m[r] + inc - dec;
        if (dec && cnt_m[r] == 0) begin nerr = 1; ncnt[r] = cnt_m[r]; end
        if (ncnt[r] > MAX) ncnt[r] = MAX;
      end
      @(posedge clk);
      for (int r = 1; r < NR; r++) cnt_m[r] = ncnt[r];
      err_m = nerr; ph_m = nph;
`ifdef SCOREBOARD_STALL_CNT_EN
      if (es) stall_m++;
`endif
      #1;
      checks++; if (drain_ack !== (ph_m == 2)) begin errors++; $display("FAIL rnd_ack cyc %0d: got %b want %b", c, drain_ack, ph_m == 2); end
      checks++; if (err !== err_m) begin errors++; $display("FAIL rnd_err cyc %0d: got %b want %b", c, err, err_m); end
`ifdef SCOREBOARD_STALL_CNT_EN
      checks++; if (stall_cycles !== 32'(stall_m)) begin errors++; $display("FAIL rnd_stallcnt cyc %0d: got %0d want %0d", c, stall_cycles, stall_m); end
`endif
    end
  endtask

  initial begin
    idle();
    rst_n = 1;
    #2;
    test_reset();
    test_raw();
    test_waw_full();
    test_inc_dec();
    test_err();
    test_drain();
    test_flush_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
